// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// One request is outstanding at a time; bus_ack completes it.
interface load_store_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: splits a RISC-V load/store into one or two word-aligned bus
// transactions, stalls the pipeline meanwhile and returns extended load data.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid_i,
    input  logic                    cmd_write_i,
    input  logic [2:0]              cmd_funct3_i,
    input  logic [31:0]             cmd_addr_i,
    input  logic [31:0]             cmd_wdata_i,
    output logic                    stall_o,
    output logic                    load_valid_o,
    output logic [31:0]             load_data_o,
    output logic                    bus_error_o,
    load_store_unit_if.master       bus
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_e;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        write_q, write_d;
    logic        split_q, split_d;
    logic [3:0]  be_hi_q, be_hi_d;
    logic [31:0] wd_hi_q, wd_hi_d;
    logic [31:0] r0_q, r0_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        lv_q, lv_d;
    logic [31:0] ld_q, ld_d;
    logic        err_q, err_d;

    logic        legal;
    logic [3:0]  mask;
    logic [7:0]  be64;
    logic [63:0] wd64;
    logic [63:0] raw64;
    logic [31:0] sh32;
    logic [31:0] ext;
    logic [31:0] result;

    // Command decode and lane positioning, straight from the pipeline inputs
    always_comb begin
        if (cmd_write_i) legal = cmd_funct3_i inside {3'b000, 3'b001, 3'b010};
        else             legal = cmd_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        case (cmd_funct3_i[1:0])
            2'b00:   mask = 4'h1;
            2'b01:   mask = 4'h3;
            default: mask = 4'hF;
        endcase
        be64 = {4'b0000, mask} << cmd_addr_i[1:0];
        wd64 = {32'b0, cmd_wdata_i} << {cmd_addr_i[1:0], 3'b000};
    end

    // In ACC1 the current rdata is the upper word of the pair
    always_comb begin
        raw64 = (state_q == ACC1) ? {bus.bus_rdata, r0_q} : {32'b0, bus.bus_rdata};
        sh32  = 32'(raw64 >> {off_q, 3'b000});
        case (funct3_q)
            3'b000:  ext = {{24{sh32[7]}}, sh32[7:0]};
            3'b100:  ext = {24'b0, sh32[7:0]};
            3'b001:  ext = {{16{sh32[15]}}, sh32[15:0]};
            3'b101:  ext = {16'b0, sh32[15:0]};
            default: ext = sh32;
        endcase
        result = write_q ? 32'b0 : ext;
    end

    always_comb begin
        state_d  = state_q;
        off_d    = off_q;
        funct3_d = funct3_q;
        write_d  = write_q;
        split_d  = split_q;
        be_hi_d  = be_hi_q;
        wd_hi_d  = wd_hi_q;
        r0_d     = r0_q;
        tmo_d    = tmo_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        lv_d     = 1'b0;
        ld_d     = ld_q;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    off_d    = cmd_addr_i[1:0];
                    funct3_d = cmd_funct3_i;
                    write_d  = cmd_write_i;
                    if (!legal) begin
                        state_d = DONE;
                        lv_d    = 1'b1;
                        err_d   = 1'b1;
                        ld_d    = 32'b0;
                    end else begin
                        state_d = ACC0;
                        split_d = |be64[7:4];
                        be_hi_d = be64[7:4];
                        wd_hi_d = cmd_write_i ? wd64[63:32] : 32'b0;
                        tmo_d   = 8'd0;
                        req_d   = 1'b1;
                        we_d    = cmd_write_i;
                        addr_d  = {cmd_addr_i[31:2], 2'b00};
                        be_d    = be64[3:0];
                        wdata_d = cmd_write_i ? wd64[31:0] : 32'b0;
                    end
                end
            end
            ACC0, ACC1: begin
                if (bus.bus_ack) begin
                    r0_d = bus.bus_rdata;
                    if (state_q == ACC0 && split_q) begin
                        state_d = ACC1;
                        tmo_d   = 8'd0;
                        addr_d  = addr_q + 32'd4;
                        be_d    = be_hi_q;
                        wdata_d = wd_hi_q;
                    end else begin
                        state_d = DONE;
                        req_d   = 1'b0;
                        lv_d    = 1'b1;
                        ld_d    = result;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    lv_d    = 1'b1;
                    err_d   = 1'b1;
                    ld_d    = 32'b0;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            off_q    <= '0;
            funct3_q <= '0;
            write_q  <= 1'b0;
            split_q  <= 1'b0;
            be_hi_q  <= '0;
            wd_hi_q  <= '0;
            r0_q     <= '0;
            tmo_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            lv_q     <= 1'b0;
            ld_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            off_q    <= off_d;
            funct3_q <= funct3_d;
            write_q  <= write_d;
            split_q  <= split_d;
            be_hi_q  <= be_hi_d;
            wd_hi_q  <= wd_hi_d;
            r0_q     <= r0_d;
            tmo_q    <= tmo_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            lv_q     <= lv_d;
            ld_q     <= ld_d;
            err_q    <= err_d;
        end
    end

    assign stall_o       = (state_q == IDLE && cmd_valid_i) || state_q == ACC0 || state_q == ACC1;
    assign load_valid_o  = lv_q;
    assign load_data_o   = ld_q;
    assign bus_error_o   = err_q;
    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly downstream of the MEM stage address/data outputs and drives the data-memory bus.
- Turns a decoded load/store into one or two word-aligned bus transactions with byte enables.
- Stalls the pipeline until the bus completes and returns sign/zero-extended load data to the MEM/WB path.
- Misaligned accesses are split into two word transactions; no misalignment trap is raised.

Parameters:
TIMEOUT_CYCLES, 255, number of cycles a bus_req may stay unacknowledged before the access is abandoned with bus_error (8-bit counter, 1..255)

Ports:
clk  input  1  clock
reset  input  1  reset; synchronous, active-high
cmd_valid  input  1  memory access requested (MEM command bit 0)
cmd_write  input  1  1 store, 0 load
cmd_funct3  input  3  RISC-V load/store funct3
cmd_addr  input  32  byte address (ALU result)
cmd_wdata  input  32  store data, LSB-aligned
stall  output  1  pipeline hold
load_valid  output  1  one-cycle pulse, load_data/bus_error valid
load_data  output  32  extended load result
bus_error  output  1  one-cycle pulse with load_valid on timeout or illegal funct3
bus_req  output  1  bus request
bus_we  output  1  bus write
bus_addr  output  32  word-aligned address, [1:0]=0
bus_be  output  4  byte enables
bus_wdata  output  32  lane-positioned write data
bus_ack  input  1  transfer complete; bus_rdata valid for reads
bus_rdata  input  32  read word

Behaviour:
- States: IDLE, ACC0, ACC1, DONE. Reset forces IDLE on the next edge, including mid-transaction.
- Reset values: bus_req 0, bus_we 0, bus_addr 0, bus_be 0, bus_wdata 0, load_valid 0, load_data 0, bus_error 0, timeout counter 0.
- A bus_ack arriving after reset is ignored.
- stall is combinational: stall = (IDLE & cmd_valid) | ACC0 | ACC1. It is 0 in DONE.
- IDLE & cmd_valid:
  - Latch addr, wdata, funct3 and write; off = addr[1:0].
  - Legal funct3: load 000/001/010/100/101; store 000/001/010.
  - Illegal funct3 → DONE with bus_error=1, load_data=0, no bus access.
  - Otherwise → ACC0 with bus_req=1 and bus_addr={addr[31:2],2'b00}.
- Lane positioning:
  - Size mask m = 0x1 for byte, 0x3 for half, 0xF for word.
  - 8-bit be64 = m << off; 64-bit wd64 = wdata << (8*off).
  - ACC0 uses be64[3:0] and wd64[31:0].
  - split = (be64[7:4] != 0). Word loads split when off != 0; half loads split only when off = 3.
  - Loads drive the same be pattern and bus_we=0.
- ACC0:
  - bus_req held high and bus_addr/be/wdata/we held stable until bus_ack.
  - Ack in the same cycle as req is legal.
  - On ack: capture bus_rdata as r0. If split → ACC1 with bus_addr+4 (wraps 0xFFFFFFFC→0x00000000), be64[7:4], wd64[63:32]. Otherwise → DONE with bus_req=0.
- ACC1: same handshake; on ack capture r1 and go to DONE.
- Load result:
  - Form {r1,r0} >> (8*off), taking the low bits.
  - 000: sign-extend byte. 100: zero-extend byte.
  - 001: sign-extend half. 101: zero-extend half.
  - 010: word.
  - Stores return load_data=0.
- DONE: load_valid=1 for exactly one cycle, then IDLE. cmd_valid seen in DONE is the completing command and is ignored; the next command is accepted in IDLE.
- Timeout:
  - Counter clears on entry to ACC0/ACC1 and increments each cycle without ack.
  - When it reaches TIMEOUT_CYCLES: drop bus_req, go to DONE with bus_error=1, load_data=0.
  - Ack in that same cycle wins.
- bus_ack in IDLE or DONE is ignored.
- Minimum latency (single aligned access, ack in first req cycle): accept cycle (stall=1) → ACC0 (stall=1, ack) → DONE. Stall is high for 2 cycles.

Test Plan:
- lw addr 0x100, ack on first req cycle, rdata 0xDEADBEEF → bus_addr 0x100, be 0xF, stall high 2 cycles, load_valid with load_data 0xDEADBEEF.
- lb addr 0x203, rdata 0x80FF_FFFF → be 0x8, load_data 0xFFFFFF80; lbu same → 0x00000080.
- sw addr 0x301, wdata 0x11223344 → tx0 addr 0x300 be 0xE wdata 0x22334400, tx1 addr 0x304 be 0x1 wdata 0x00000011, then load_valid with load_data 0.
- lh addr 0xFFFFFFFF, rdata0 0xAB000000, rdata1 0x000000CD → tx1 addr 0x00000000, load_data 0xFFFFCDAB.
- No ack with TIMEOUT_CYCLES=4 → bus_req drops after 4 cycles, load_valid and bus_error pulse, load_data 0.
- Reset asserted in ACC1, then a late ack → IDLE next edge, all outputs at reset values, no load_valid.
